// File: rtl/buzzer_arb.sv
// Fixed-priority arbiter for the shared buzzer counter: latches one-cycle beep
// requests, grants one source per burst and paces bursts on the 1 kHz tick.
module buzzer_arb #(
  parameter int N        = 4,
  parameter int BURST_MS = 256,
  parameter int GAP_MS   = 20
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_pls_1k,
  input  logic [N-1:0] i_req,
  input  logic         i_mute,
  output logic         o_go,
  output logic [N-1:0] o_grant,
  output logic         o_busy,
  output logic [N-1:0] o_pend
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [15:0] BURST_LAST = 16'(BURST_MS - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_MS - 1);

  logic [1:0]   state;
  logic [15:0]  cnt;
  logic [N-1:0] pend_q;
  logic [N-1:0] pick;
  logic [N-1:0] clr;
  logic [N-1:0] pend_d;
  logic         do_grant;

  function automatic logic [N-1:0] lowest_onehot(input logic [N-1:0] v);
    logic [N-1:0] r;
    logic         found;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (v[k] && !found) begin
        r[k]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // A fresh request in the grant cycle re-arms the bit; mute overrides everything.
  always_comb begin
    pick     = lowest_onehot(pend_q);
    do_grant = (state == S_IDLE) && (|pend_q) && !i_mute;
    clr      = do_grant ? pick : '0;
    pend_d   = i_mute ? '0 : ((pend_q & ~clr) | i_req);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend_q  <= '0;
      o_go    <= 1'b0;
      o_grant <= '0;
    end else begin
      pend_q <= pend_d;
      o_go   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (do_grant) begin
            state   <= S_PLAY;
            cnt     <= '0;
            o_go    <= 1'b1;
            o_grant <= pick;
          end
        end
        S_PLAY: begin
          if (i_pls_1k) begin
            if (cnt == BURST_LAST) begin
              cnt <= '0;
              // With no guard gap the next grant may follow on the very next clock.
              if (GAP_MS == 0) begin
                state   <= S_IDLE;
                o_grant <= '0;
              end else begin
                state <= S_GAP;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (GAP_MS == 0 || (i_pls_1k && cnt == GAP_LAST)) begin
            state   <= S_IDLE;
            cnt     <= '0;
            o_grant <= '0;
          end else if (i_pls_1k) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          o_grant <= '0;
        end
      endcase
    end
  end

  assign o_pend = pend_q;
  assign o_busy = (state != S_IDLE);

endmodule
